usb_host_speed_detector_mp: RTL and testbench
=============================================

Name: usb_host_speed_detector_mp

Overview:
Multi-port successor to the single-port host speed detector. For each of NUM_PORTS downstream ports it synchronises the raw D+/D- pair, filters attach with a debounce counter, and classifies the device as low- or full-speed from the idle line level. It exports per-port J/K/idle encodings for the downstream packet engines. It filters detach from bus-reset and EOP SE0s with a second counter and emits one-cycle attach/detach events to the hub status logic.

Parameters:
NUM_PORTS, 4, number of independent downstream ports
DEBOUNCE_CYCLES, 8, consecutive identical idle samples required to declare attach (>=2)
DETACH_CYCLES, 16, consecutive SE0 samples required to declare detach (>=2)
CNT_W, $clog2(max(DEBOUNCE_CYCLES,DETACH_CYCLES)+1), per-port counter width (derived)

Ports:
clock  input  1  single system clock, all logic on posedge
reset  input  1  asynchronous, active-low reset
usb_signals  input  2*NUM_PORTS  raw {dp,dm} per port; port p uses bits [2p+1:2p], dp is the MSB
port_en  input  NUM_PORTS  per-port enable; 0 forces the port to DISCONNECTED
speed  output  2*NUM_PORTS  per port: 00 none, 01 low, 10 full, 11 never driven
attached  output  NUM_PORTS  level, high while the port is in CONNECTED or DETACH_CHK
attach_evt  output  NUM_PORTS  one-cycle pulse on entry to CONNECTED from DEBOUNCE
detach_evt  output  NUM_PORTS  one-cycle pulse on DETACH_CHK -> DISCONNECTED
j_state  output  2*NUM_PORTS  per-port J line code: FS 10, LS 01, none 00
k_state  output  2*NUM_PORTS  per-port K line code: FS 01, LS 10, none 00
idle_state  output  2*NUM_PORTS  per-port idle code, equal to j_state

Behaviour:
- Reset (reset=0, asynchronous): all synchronisers 00, every port in DISCONNECTED, counters 0, all outputs 0.
- Synchroniser: 2-flop per bit; the sampled line state ls is 2 cycles behind usb_signals.
- Line decode of ls: 00 SE0; 10 FS-idle; 01 LS-idle; 11 SE1 (illegal).
- Per-port FSM, ports fully independent.
- DISCONNECTED:
  - ls = 10 or 01: go to DEBOUNCE, cnt=1, cand=ls.
  - SE0 or SE1: stay.
- DEBOUNCE:
  - ls == cand: cnt++.
  - ls is the other idle code: cand=ls, cnt=1.
  - SE1: cnt=0, stay; the next idle sample sets cand and cnt=1.
  - SE0: back to DISCONNECTED, no event.
  - cnt reaches DEBOUNCE_CYCLES: next cycle enter CONNECTED, latch speed (10 -> full, 01 -> low), attach_evt=1 for exactly that cycle.
- CONNECTED:
  - Outputs are valid and static.
  - K, J or SE1 traffic: ignored.
  - SE0: go to DETACH_CHK, cnt=1.
- DETACH_CHK:
  - attached stays 1 and speed is held.
  - Any non-SE0 sample: back to CONNECTED, cnt=0, no event (short SE0 such as EOP or bus reset).
  - cnt reaches DETACH_CYCLES: next cycle enter DISCONNECTED, speed=00, j/k/idle=00, detach_evt=1 for that cycle.
- port_en=0 (synchronous, any state): DISCONNECTED next cycle, cnt=0, outputs cleared. detach_evt pulses if the port was attached; attach_evt never pulses.
- Counters saturate; they never wrap.
- Attach latency: first idle edge at the pins -> attach_evt is DEBOUNCE_CYCLES+2 cycles.
- Detach latency: SE0 start at the pins -> detach_evt is DETACH_CYCLES+2 cycles.
- Reset mid-operation: immediate return to reset values, no events.
- attach_evt and detach_evt are never high together on the same port.

Test Plan:
1. Reset=0 then 1, all pins 00 for 20 cycles -> all outputs 0, no events.
2. Port 0: pins 00 -> 10 held, DEBOUNCE_CYCLES=8 -> attach_evt[0] exactly 10 cycles after the edge; speed[1:0]=10, j_state[1:0]=10, k_state[1:0]=01; other ports unchanged.
3. Port 2: 01 held for 5 cycles, one SE0 cycle, then 01 held -> no event from the first burst; attach_evt[2] 10 cycles after the second edge; speed=01, j=01, k=10.
4. Port 0 attached FS: SE0 for 10 cycles then J (DETACH_CYCLES=16) -> attached stays 1, no detach_evt; then SE0 held -> detach_evt[0] 18 cycles after SE0 start, speed=00.
5. Port 1: 10 for 4 cycles then 01 -> cand restarts; attach_evt[1] 10 cycles after the 01 edge with speed=01.
6. Ports 0 and 3 attached: drop port_en[3] -> detach_evt[3] next cycle, outputs cleared. Assert reset mid-debounce on port 1 -> immediate clear, no pulse; port 0 also cleared.

Source files
------------

// File: rtl/usb_host_speed_detector_mp.sv
// Multi-port USB host attach/detach and speed detector: per-port line synchroniser,
// attach debounce, detach filter against EOP/bus-reset SE0, and J/K/idle line codes.
//
// state         | meaning
// DISCONNECTED  | no device; waiting for an idle line level
// DEBOUNCE      | idle level seen; counting consecutive matching samples
// CONNECTED     | device attached; speed latched, line traffic ignored
// DETACH_CHK    | SE0 seen while attached; counting to tell detach from EOP/reset
module usb_host_speed_detector_mp #(
  parameter int NUM_PORTS       = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int DETACH_CYCLES   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2*NUM_PORTS-1:0] usb_signals,
  input  logic [NUM_PORTS-1:0]   port_en,
  output logic [2*NUM_PORTS-1:0] speed,
  output logic [NUM_PORTS-1:0]   attached,
  output logic [NUM_PORTS-1:0]   attach_evt,
  output logic [NUM_PORTS-1:0]   detach_evt,
  output logic [2*NUM_PORTS-1:0] j_state,
  output logic [2*NUM_PORTS-1:0] k_state,
  output logic [2*NUM_PORTS-1:0] idle_state
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > DETACH_CYCLES) ? DEBOUNCE_CYCLES : DETACH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // A count at these values plus one more matching sample reaches the threshold.
  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DET_TC = CNT_W'(DETACH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_DISCONNECTED = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_CONNECTED    = 2'd2,
    ST_DETACH_CHK   = 2'd3
  } port_state_e;

  logic [2*NUM_PORTS-1:0] sync1_q, sync2_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= usb_signals;
      sync2_q <= sync1_q;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    port_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cand_q, cand_d;
    logic [1:0]       speed_q, speed_d;
    logic             attach_evt_q, attach_evt_d;
    logic             detach_evt_q, detach_evt_d;
    logic [1:0]       ls;
    logic             ls_idle;
    logic             ls_se0;

    assign ls      = sync2_q[2*p +: 2];
    assign ls_idle = (ls == 2'b10) || (ls == 2'b01);
    assign ls_se0  = (ls == 2'b00);

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_q      <= ST_DISCONNECTED;
        cnt_q        <= '0;
        cand_q       <= '0;
        speed_q      <= '0;
        attach_evt_q <= 1'b0;
        detach_evt_q <= 1'b0;
      end else begin
        state_q      <= state_d;
        cnt_q        <= cnt_d;
        cand_q       <= cand_d;
        speed_q      <= speed_d;
        attach_evt_q <= attach_evt_d;
        detach_evt_q <= detach_evt_d;
      end
    end

    always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cand_d       = cand_q;
      speed_d      = speed_q;
      attach_evt_d = 1'b0;
      detach_evt_d = 1'b0;

      if (!port_en[p]) begin
        state_d      = ST_DISCONNECTED;
        cnt_d        = '0;
        cand_d       = '0;
        speed_d      = '0;
        detach_evt_d = (state_q == ST_CONNECTED) || (state_q == ST_DETACH_CHK);
      end else begin
        unique case (state_q)
          ST_DISCONNECTED: begin
            if (ls_idle) begin
              state_d = ST_DEBOUNCE;
              cnt_d   = CNT_ONE;
              cand_d  = ls;
            end
          end
          ST_DEBOUNCE: begin
            if (ls_se0) begin
              state_d = ST_DISCONNECTED;
              cnt_d   = '0;
              cand_d  = '0;
            end else if (!ls_idle) begin
              cnt_d = '0;
            end else if ((cnt_q == '0) || (ls != cand_q)) begin
              // After an SE1 or a switch of idle level the run starts over.
              cand_d = ls;
              cnt_d  = CNT_ONE;
            end else if (cnt_q >= DEB_TC) begin
              state_d      = ST_CONNECTED;
              cnt_d        = '0;
              speed_d      = cand_q;
              attach_evt_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          ST_CONNECTED: begin
            if (ls_se0) begin
              state_d = ST_DETACH_CHK;
              cnt_d   = CNT_ONE;
            end
          end
          ST_DETACH_CHK: begin
            if (!ls_se0) begin
              state_d = ST_CONNECTED;
              cnt_d   = '0;
            end else if (cnt_q >= DET_TC) begin
              state_d      = ST_DISCONNECTED;
              cnt_d        = '0;
              cand_d       = '0;
              speed_d      = '0;
              detach_evt_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = ST_DISCONNECTED;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Speed code doubles as the J level: FS 10, LS 01; K is its mirror.
    assign speed[2*p +: 2]      = speed_q;
    assign j_state[2*p +: 2]    = speed_q;
    assign idle_state[2*p +: 2] = speed_q;
    assign k_state[2*p +: 2]    = {speed_q[0], speed_q[1]};
    assign attached[p]          = (state_q == ST_CONNECTED) || (state_q == ST_DETACH_CHK);
    assign attach_evt[p]        = attach_evt_q;
    assign detach_evt[p]        = detach_evt_q;
  end

endmodule

// File: tb/tb_usb_host_speed_detector_mp.sv
// Self-checking bench for usb_host_speed_detector_mp: scenario tasks check levels inline,
// a negedge monitor matches attach/detach pulses against a queue of expected events.
module tb_usb_host_speed_detector_mp;
  localparam int NP  = 4;
  localparam int DEB = 8;
  localparam int DET = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic [2*NP-1:0] usb_signals;
  logic [NP-1:0]   port_en;
  logic [2*NP-1:0] speed, j_state, k_state, idle_state;
  logic [NP-1:0]   attached, attach_evt, detach_evt;

  usb_host_speed_detector_mp #(
    .NUM_PORTS(NP), .DEBOUNCE_CYCLES(DEB), .DETACH_CYCLES(DET)
  ) dut (
    .clock(clock), .reset(reset), .usb_signals(usb_signals), .port_en(port_en),
    .speed(speed), .attached(attached), .attach_evt(attach_evt), .detach_evt(detach_evt),
    .j_state(j_state), .k_state(k_state), .idle_state(idle_state)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int port;
    bit is_attach;
    int cyc;
  } evt_t;

  evt_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(negedge clock) begin
    for (int p = 0; p < NP; p++) begin
      if (attach_evt[p] || detach_evt[p]) begin : chk_evt
        int idx;
        bit kind;
        idx  = -1;
        kind = attach_evt[p];
        n_checks++;
        if (attach_evt[p] && detach_evt[p])
          $display("FAIL evt_exclusive port %0d: attach=1 detach=1, required at most one", p);
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++)
          if (idx < 0 && exp_q[i].port == p && exp_q[i].is_attach == kind) idx = i;
        n_checks++;
        if (idx < 0) begin
          $display("FAIL unexpected_evt port %0d attach=%0d at cycle %0d, required none", p, kind, cyc);
        end else begin
          if (exp_q[idx].cyc !== cyc)
            $display("FAIL evt_cycle port %0d attach=%0d: got cycle %0d, required %0d",
                     p, kind, cyc, exp_q[idx].cyc);
          else n_pass++;
          exp_q.delete(idx);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_pins(input int p, input logic [1:0] v);
    usb_signals[2*p +: 2] = v;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    usb_signals = '0;
    port_en = '1;
    step(3);
    n_checks++;
    if (attached !== '0) $display("FAIL reset_attached: got %b, required 0", attached); else n_pass++;
    n_checks++;
    if (speed !== '0) $display("FAIL reset_speed: got %h, required 0", speed); else n_pass++;
    reset = 1'b1;
    step(20);
    n_checks++;
    if (attached !== '0) $display("FAIL idle_attached: got %b, required 0", attached); else n_pass++;
    n_checks++;
    if (speed !== '0) $display("FAIL idle_speed: got %h, required 0", speed); else n_pass++;
    n_checks++;
    if ({j_state, k_state, idle_state} !== '0)
      $display("FAIL idle_line_codes: got j=%h k=%h idle=%h, required 0", j_state, k_state, idle_state);
    else n_pass++;
  endtask

  task automatic test_attach_fs;
    int c0;
    c0 = cyc;
    set_pins(0, 2'b10);
    exp_q.push_back('{port: 0, is_attach: 1'b1, cyc: c0 + DEB + 2});
    step(DEB + 1);
    n_checks++;
    if (attached[0] !== 1'b0) $display("FAIL fs_early_attach: got %b, required 0", attached[0]); else n_pass++;
    step(2);
    n_checks++;
    if (speed[1:0] !== 2'b10) $display("FAIL fs_speed: got %b, required 10", speed[1:0]); else n_pass++;
    n_checks++;
    if (j_state[1:0] !== 2'b10 || idle_state[1:0] !== 2'b10)
      $display("FAIL fs_j_idle: got j=%b idle=%b, required 10", j_state[1:0], idle_state[1:0]);
    else n_pass++;
    n_checks++;
    if (k_state[1:0] !== 2'b01) $display("FAIL fs_k: got %b, required 01", k_state[1:0]); else n_pass++;
    n_checks++;
    if (attached !== 4'b0001 || speed[7:2] !== 6'b0)
      $display("FAIL fs_other_ports: got attached=%b speed=%h, required 0001/02", attached, speed);
    else n_pass++;
  endtask

  task automatic test_ls_glitch;
    int c1;
    set_pins(2, 2'b01);
    step(5);
    set_pins(2, 2'b00);
    step(1);
    c1 = cyc;
    set_pins(2, 2'b01);
    exp_q.push_back('{port: 2, is_attach: 1'b1, cyc: c1 + DEB + 2});
    step(DEB + 1);
    n_checks++;
    if (attached[2] !== 1'b0) $display("FAIL ls_early_attach: got %b, required 0", attached[2]); else n_pass++;
    step(2);
    n_checks++;
    if (speed[5:4] !== 2'b01) $display("FAIL ls_speed: got %b, required 01", speed[5:4]); else n_pass++;
    n_checks++;
    if (j_state[5:4] !== 2'b01 || k_state[5:4] !== 2'b10)
      $display("FAIL ls_jk: got j=%b k=%b, required 01/10", j_state[5:4], k_state[5:4]);
    else n_pass++;
    n_checks++;
    if (attached !== 4'b0101) $display("FAIL ls_attached: got %b, required 0101", attached); else n_pass++;
  endtask

  task automatic test_detach_filter;
    int c1;
    set_pins(0, 2'b00);
    step(8);
    n_checks++;
    if (attached[0] !== 1'b1 || speed[1:0] !== 2'b10)
      $display("FAIL se0_hold: got attached=%b speed=%b, required 1/10", attached[0], speed[1:0]);
    else n_pass++;
    step(2);
    set_pins(0, 2'b10);
    step(5);
    n_checks++;
    if (attached[0] !== 1'b1) $display("FAIL short_se0_attached: got %b, required 1", attached[0]); else n_pass++;
    c1 = cyc;
    set_pins(0, 2'b00);
    exp_q.push_back('{port: 0, is_attach: 1'b0, cyc: c1 + DET + 2});
    step(DET + 1);
    n_checks++;
    if (attached[0] !== 1'b1) $display("FAIL detach_early: got %b, required 1", attached[0]); else n_pass++;
    step(2);
    n_checks++;
    if (attached[0] !== 1'b0 || speed[1:0] !== 2'b00)
      $display("FAIL detach_clear: got attached=%b speed=%b, required 0/00", attached[0], speed[1:0]);
    else n_pass++;
    n_checks++;
    if (j_state[1:0] !== 2'b00 || k_state[1:0] !== 2'b00)
      $display("FAIL detach_jk: got j=%b k=%b, required 00/00", j_state[1:0], k_state[1:0]);
    else n_pass++;
  endtask

  task automatic test_cand_restart;
    int c1;
    set_pins(1, 2'b10);
    step(4);
    c1 = cyc;
    set_pins(1, 2'b01);
    exp_q.push_back('{port: 1, is_attach: 1'b1, cyc: c1 + DEB + 2});
    step(DEB + 3);
    n_checks++;
    if (speed[3:2] !== 2'b01 || k_state[3:2] !== 2'b10)
      $display("FAIL restart_speed: got speed=%b k=%b, required 01/10", speed[3:2], k_state[3:2]);
    else n_pass++;
    n_checks++;
    if (attached !== 4'b0110) $display("FAIL restart_attached: got %b, required 0110", attached); else n_pass++;
  endtask

  task automatic test_en_and_reset;
    int c0;
    c0 = cyc;
    set_pins(1, 2'b00);
    set_pins(0, 2'b10);
    set_pins(3, 2'b01);
    exp_q.push_back('{port: 1, is_attach: 1'b0, cyc: c0 + DET + 2});
    exp_q.push_back('{port: 0, is_attach: 1'b1, cyc: c0 + DEB + 2});
    exp_q.push_back('{port: 3, is_attach: 1'b1, cyc: c0 + DEB + 2});
    step(20);
    n_checks++;
    if (attached !== 4'b1101 || speed !== 8'h52)
      $display("FAIL multi_attach: got attached=%b speed=%h, required 1101/52", attached, speed);
    else n_pass++;
    c0 = cyc;
    port_en[3] = 1'b0;
    exp_q.push_back('{port: 3, is_attach: 1'b0, cyc: c0 + 1});
    step(1);
    n_checks++;
    if (attached[3] !== 1'b0 || speed[7:6] !== 2'b00 || j_state[7:6] !== 2'b00)
      $display("FAIL en_clear: got attached=%b speed=%b j=%b, required 0/00/00",
               attached[3], speed[7:6], j_state[7:6]);
    else n_pass++;
    step(3);
    n_checks++;
    if (attached !== 4'b0101) $display("FAIL en_held: got %b, required 0101", attached); else n_pass++;
    set_pins(1, 2'b10);
    step(4);
    reset = 1'b0;
    #1;
    n_checks++;
    if (attached !== '0 || speed !== '0)
      $display("FAIL midreset_clear: got attached=%b speed=%h, required 0/0", attached, speed);
    else n_pass++;
    n_checks++;
    if ({j_state, k_state, idle_state, attach_evt, detach_evt} !== '0)
      $display("FAIL midreset_outputs: got j=%h k=%h evt=%b/%b, required 0",
               j_state, k_state, attach_evt, detach_evt);
    else n_pass++;
    usb_signals = '0;
    port_en = '1;
    step(2);
    reset = 1'b1;
    step(20);
    n_checks++;
    if (attached !== '0 || speed !== '0)
      $display("FAIL post_reset: got attached=%b speed=%h, required 0/0", attached, speed);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_attach_fs();
    test_ls_glitch();
    test_detach_filter();
    test_cand_restart();
    test_en_and_reset();
    step(2);
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL missing_evts: got %0d pending, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
